// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the sram-like two-master arbiter: FSM states, owner ids
// and transfer size codes.
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter_grant.sv
// Combinational winner selection between inst and data masters.
// ARB_ROUND_ROBIN_EN selects round-robin; otherwise data has fixed priority.
module sram_like_grant
  import sram_like_arbiter_pkg::*;
(
  input  logic   i_inst_req,
  input  logic   i_data_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_t i_last_owner,
`endif
  output owner_t o_grant
);

  // Pick the winner for the current IDLE cycle
  always_comb begin
    o_grant = OWN_INST;
`ifdef ARB_ROUND_ROBIN_EN
    if (i_inst_req && i_data_req) begin
      o_grant = (i_last_owner == OWN_INST) ? OWN_DATA : OWN_INST;
    end else if (i_data_req) begin
      o_grant = OWN_DATA;
    end else begin
      o_grant = OWN_INST;
    end
`else
    if (i_data_req) begin
      o_grant = OWN_DATA;
    end else begin
      o_grant = OWN_INST;
    end
`endif
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like slave between an inst and a data master, one transfer
// in flight. Define ARB_ROUND_ROBIN_EN for round-robin instead of data priority.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       inst_wdata,
  output logic [31:0]       inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok
);

  state_t r_state;
  owner_t r_owner;
  owner_t w_grant;
  logic   w_owner_req;
  logic   w_addr_ok;
  logic   w_data_ok;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t r_last_owner;

  sram_like_grant u_grant (
    .i_inst_req   (inst_req),
    .i_data_req   (data_req),
    .i_last_owner (r_last_owner),
    .o_grant      (w_grant)
  );

  // Round-robin pointer follows each grant taken in IDLE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_owner <= OWN_INST;
    end else if (r_state == ST_IDLE && (inst_req || data_req)) begin
      r_last_owner <= w_grant;
    end else begin
      r_last_owner <= r_last_owner;
    end
  end
`else
  sram_like_grant u_grant (
    .i_inst_req (inst_req),
    .i_data_req (data_req),
    .o_grant    (w_grant)
  );
`endif

  assign w_owner_req = (r_owner == OWN_DATA) ? data_req : inst_req;

  // Transaction FSM; a dropped request in ADDR abandons the transfer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_INST;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (inst_req || data_req) begin
            r_owner <= w_grant;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (!w_owner_req) begin
            r_state <= ST_IDLE;
          end else if (bus_addr_ok) begin
            r_state <= bus_data_ok ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus_data_ok) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_owner <= OWN_INST;
        end
      endcase
    end
  end

  // Bus request mux and handshake routing to the current owner only
  always_comb begin
    bus_req   = (r_state == ST_ADDR) && w_owner_req;
    bus_wr    = 1'b0;
    bus_size  = 2'd0;
    bus_addr  = '0;
    bus_wdata = 32'd0;
    if (r_owner == OWN_DATA) begin
      bus_wr    = data_wr;
      bus_size  = data_size;
      bus_addr  = data_addr;
      bus_wdata = data_wdata;
    end else begin
      bus_wr    = inst_wr;
      bus_size  = inst_size;
      bus_addr  = inst_addr;
      bus_wdata = inst_wdata;
    end
    w_addr_ok = bus_req && bus_addr_ok;
    w_data_ok = ((r_state == ST_DATA) && bus_data_ok) || (w_addr_ok && bus_data_ok);
  end

  assign inst_addr_ok = w_addr_ok && (r_owner == OWN_INST);
  assign data_addr_ok = w_addr_ok && (r_owner == OWN_DATA);
  assign inst_data_ok = w_data_ok && (r_owner == OWN_INST);
  assign data_data_ok = w_data_ok && (r_owner == OWN_DATA);
  assign inst_rdata   = (r_owner == OWN_INST) ? bus_rdata : 32'd0;
  assign data_rdata   = (r_owner == OWN_DATA) ? bus_rdata : 32'd0;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter; inputs change on the
// falling edge and outputs are sampled 1ns later.
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, bus_size;
  logic [31:0] inst_addr, data_addr, bus_addr;
  logic [31:0] inst_wdata, data_wdata, bus_wdata;
  logic [31:0] inst_rdata, data_rdata, bus_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok)
  );

  task automatic clear_inputs();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = SIZE_WORD; inst_addr = 32'd0; inst_wdata = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = SIZE_WORD; data_addr = 32'd0; data_wdata = 32'd0;
    bus_rdata = 32'd0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({bus_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 00000", {bus_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok});
    end
    n_checks++;
    if (dut.r_state !== ST_IDLE || dut.r_owner !== OWN_INST) begin
      n_fail++; $display("FAIL reset_state: got state %0d owner %0d want 0 0", dut.r_state, dut.r_owner);
    end
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    // bring a data read into ADDR, then pull reset mid-cycle
    @(negedge clk);
    data_req = 1'b1; data_addr = 32'h0000_0400;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus_req !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_addr_req: got %b want 1", bus_req);
    end
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (bus_req !== 1'b0 || dut.r_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_mid_addr: got bus_req %b state %0d want 0 0", bus_req, dut.r_state);
    end
    @(negedge clk);
    data_req = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_data_ok: got data %b inst %b want 0 0", data_data_ok, inst_data_ok);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_single_read();
    @(negedge clk);
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = SIZE_WORD; inst_addr = 32'hBFC0_0000;
    #1;
    n_checks++;
    if (bus_req !== 1'b0) begin
      n_fail++; $display("FAIL read_idle_req: got %b want 0", bus_req);
    end
    @(negedge clk);
    bus_addr_ok = 1'b1;
    #1;
    n_checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'hBFC0_0000 || bus_wr !== 1'b0) begin
      n_fail++; $display("FAIL read_addr_phase: got req %b addr %h wr %b want 1 bfc00000 0", bus_req, bus_addr, bus_wr);
    end
    n_checks++;
    if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
      n_fail++; $display("FAIL read_addr_ok: got inst %b data %b want 1 0", inst_addr_ok, data_addr_ok);
    end
    @(negedge clk);
    inst_req = 1'b0; bus_addr_ok = 1'b0;
    #1;
    n_checks++;
    if (bus_req !== 1'b0 || inst_data_ok !== 1'b0) begin
      n_fail++; $display("FAIL read_wait: got req %b data_ok %b want 0 0", bus_req, inst_data_ok);
    end
    @(negedge clk);
    bus_data_ok = 1'b1; bus_rdata = 32'h3C08_0001;
    #1;
    n_checks++;
    if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h3C08_0001) begin
      n_fail++; $display("FAIL read_data: got ok %b rdata %h want 1 3c080001", inst_data_ok, inst_rdata);
    end
    n_checks++;
    if (data_data_ok !== 1'b0 || data_addr_ok !== 1'b0 || data_rdata !== 32'd0) begin
      n_fail++; $display("FAIL read_data_silent: got ok %b aok %b rdata %h want 0 0 0", data_data_ok, data_addr_ok, data_rdata);
    end
    @(negedge clk);
    bus_data_ok = 1'b0;
    #1;
    n_checks++;
    if (inst_data_ok !== 1'b0 || dut.r_state !== ST_IDLE) begin
      n_fail++; $display("FAIL read_done: got ok %b state %0d want 0 0", inst_data_ok, dut.r_state);
    end
    clear_inputs();
  endtask

  task automatic test_fixed_priority();
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h0000_2000;
    data_req = 1'b1; data_addr = 32'h0000_1000;
    @(negedge clk);
    bus_addr_ok = 1'b1;
    #1;
    n_checks++;
    if (bus_addr !== 32'h0000_1000 || data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
      n_fail++; $display("FAIL prio_first_addr: got addr %h daok %b iaok %b want 00001000 1 0", bus_addr, data_addr_ok, inst_addr_ok);
    end
    @(negedge clk);
    data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hAAAA_5555;
    #1;
    n_checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'hAAAA_5555 || inst_data_ok !== 1'b0 || inst_rdata !== 32'd0) begin
      n_fail++; $display("FAIL prio_first_data: got dok %b drd %h iok %b ird %h want 1 aaaa5555 0 0", data_data_ok, data_rdata, inst_data_ok, inst_rdata);
    end
    @(negedge clk);
    bus_data_ok = 1'b0;
    #1;
    n_checks++;
    if (bus_req !== 1'b0) begin
      n_fail++; $display("FAIL prio_bubble: got %b want 0", bus_req);
    end
    @(negedge clk);
    bus_addr_ok = 1'b1;
    #1;
    n_checks++;
    if (bus_addr !== 32'h0000_2000 || inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
      n_fail++; $display("FAIL prio_second_addr: got addr %h iaok %b daok %b want 00002000 1 0", bus_addr, inst_addr_ok, data_addr_ok);
    end
    @(negedge clk);
    inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    #1;
    n_checks++;
    if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin
      n_fail++; $display("FAIL prio_second_data: got iok %b dok %b want 1 0", inst_data_ok, data_data_ok);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic exp_data [4];
`ifdef ARB_ROUND_ROBIN_EN
    exp_data = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_data = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h0000_00A0;
    data_req = 1'b1; data_addr = 32'h0000_00D0;
    for (int t = 0; t < 4; t++) begin
      #1;
      n_checks++;
      if (bus_req !== 1'b0) begin
        n_fail++; $display("FAIL b2b_bubble_%0d: got %b want 0", t, bus_req);
      end
      @(negedge clk);
      bus_addr_ok = 1'b1;
      #1;
      n_checks++;
      if (bus_addr !== (exp_data[t] ? 32'h0000_00D0 : 32'h0000_00A0) ||
          data_addr_ok !== exp_data[t] || inst_addr_ok !== !exp_data[t]) begin
        n_fail++; $display("FAIL b2b_owner_%0d: got addr %h daok %b iaok %b want data=%b", t, bus_addr, data_addr_ok, inst_addr_ok, exp_data[t]);
      end
      @(negedge clk);
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
      #1;
      n_checks++;
      if (data_data_ok !== exp_data[t] || inst_data_ok !== !exp_data[t]) begin
        n_fail++; $display("FAIL b2b_data_%0d: got dok %b iok %b want data=%b", t, data_data_ok, inst_data_ok, exp_data[t]);
      end
      @(negedge clk);
      bus_data_ok = 1'b0;
    end
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_size = SIZE_WORD;
    data_addr = 32'h0000_0080; data_wdata = 32'h1234_5678;
    @(negedge clk);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    #1;
    n_checks++;
    if (bus_wr !== 1'b1 || bus_wdata !== 32'h1234_5678 || bus_size !== 2'd2 || bus_addr !== 32'h0000_0080) begin
      n_fail++; $display("FAIL same_bus: got wr %b wdata %h size %0d addr %h want 1 12345678 2 00000080", bus_wr, bus_wdata, bus_size, bus_addr);
    end
    n_checks++;
    if (data_addr_ok !== 1'b1 || data_data_ok !== 1'b1 || inst_addr_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
      n_fail++; $display("FAIL same_handshake: got daok %b dok %b iaok %b iok %b want 1 1 0 0", data_addr_ok, data_data_ok, inst_addr_ok, inst_data_ok);
    end
    @(negedge clk);
    data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    #1;
    n_checks++;
    if (dut.r_state !== ST_IDLE || bus_req !== 1'b0 || data_data_ok !== 1'b0) begin
      n_fail++; $display("FAIL same_idle: got state %0d req %b dok %b want 0 0 0", dut.r_state, bus_req, data_data_ok);
    end
    clear_inputs();
  endtask

  task automatic test_drop();
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h0000_0300;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus_req !== 1'b1) begin
      n_fail++; $display("FAIL drop_addr_req: got %b want 1", bus_req);
    end
    @(negedge clk);
    inst_req = 1'b0;
    #1;
    n_checks++;
    if (bus_req !== 1'b0 || inst_addr_ok !== 1'b0) begin
      n_fail++; $display("FAIL drop_release: got req %b iaok %b want 0 0", bus_req, inst_addr_ok);
    end
    @(negedge clk);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    #1;
    n_checks++;
    if ({bus_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 5'b0 || dut.r_state !== ST_IDLE) begin
      n_fail++; $display("FAIL drop_silent: got %b state %0d want 00000 0", {bus_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, dut.r_state);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
`ifndef ARB_ROUND_ROBIN_EN
    test_fixed_priority();
`endif
    test_same_cycle();
    test_drop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
